// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM carrier and its shadow registers.
package pwm_pkg;

  // Carrier shape selected by mode_in.
  localparam logic MODE_TRIANGLE = 1'b0;
  localparam logic MODE_SAWTOOTH = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // 4000 gives a 5 kHz triangle at 40 MHz.
  localparam int unsigned DEF_CNT_WIDTH    = 16;
  localparam int unsigned DEF_RESET_PERIOD = 4000;

endpackage

// File: rtl/pwm_shadow_reg.sv
// Shadow register: the clamped value and mode are loaded only when load is high.
// The next value is also exported so that registered outputs that depend on it can be
// produced in the same cycle as the load.
module pwm_shadow_reg
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_CNT_WIDTH,
  parameter int unsigned RESET_VALUE = DEF_RESET_PERIOD,
  parameter int unsigned MIN_VALUE   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value_in,
  input  logic             mode_in,
  output logic [WIDTH-1:0] value_next,
  output logic             mode_next,
  output logic [WIDTH-1:0] value,
  output logic             mode
);

  localparam logic [WIDTH-1:0] MinVal = WIDTH'(MIN_VALUE);
  localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] clamped;

  // Clamp the request and select between holding and loading.
  always_comb begin
    clamped    = (value_in < MinVal) ? MinVal : value_in;
    value_next = load ? clamped : value;
    mode_next  = load ? mode_in : mode;
  end

  // Active value and mode registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= RstVal;
      mode  <= MODE_TRIANGLE;
    end else begin
      value <= value_next;
      mode  <= mode_next;
    end
  end

endmodule

// File: rtl/pwm_carrier_gen.sv
// Triangle / sawtooth PWM carrier with valley-loaded peak and mode, sync restart and
// valley, peak and ADC capture strobes. All outputs are registered.
module pwm_carrier_gen
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int unsigned RESET_PERIOD = DEF_RESET_PERIOD,
  parameter int unsigned CAPTURE_WIN  = 100,
  parameter int unsigned MIN_PERIOD   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sync_in,
  input  logic                 mode_in,
  input  logic [CNT_WIDTH-1:0] period_in,
  output logic [CNT_WIDTH-1:0] carrier_count,
  output logic                 count_dir,
  output logic                 new_cycle,
  output logic                 peak,
  output logic                 data_capture,
  output logic [CNT_WIDTH-1:0] active_period
);

  localparam logic [CNT_WIDTH:0]   CaptureWin = (CNT_WIDTH + 1)'(CAPTURE_WIN);
  localparam logic [CNT_WIDTH-1:0] One        = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_d;
  logic                 dir_d;
  logic                 load;
  logic                 active_mode;
  logic [CNT_WIDTH-1:0] period_next;
  logic                 mode_next;
  logic                 new_cycle_d, peak_d, capture_d;
  logic [CNT_WIDTH:0]   period_ext, saw_thresh;

  pwm_shadow_reg #(
    .WIDTH      (CNT_WIDTH),
    .RESET_VALUE(RESET_PERIOD),
    .MIN_VALUE  (MIN_PERIOD)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .value_in  (period_in),
    .mode_in   (mode_in),
    .value_next(period_next),
    .mode_next (mode_next),
    .value     (active_period),
    .mode      (active_mode)
  );

  // Next state, count and direction; any edge landing on zero shadow-loads.
  always_comb begin
    state_d = state_q;
    count_d = carrier_count;
    dir_d   = count_dir;
    if (!enable) begin
      state_d = ST_IDLE;
      count_d = '0;
      dir_d   = 1'b0;
    end else if (state_q == ST_IDLE || sync_in) begin
      state_d = ST_RUN;
      count_d = '0;
      dir_d   = 1'b0;
    end else if (active_mode == MODE_SAWTOOTH) begin
      count_d = (carrier_count >= active_period) ? '0 : carrier_count + One;
      dir_d   = 1'b0;
    end else if (!count_dir) begin
      count_d = carrier_count + One;
      dir_d   = (count_d == active_period);
    end else begin
      count_d = carrier_count - One;
      dir_d   = (count_d != '0);
    end
    load = (count_d == '0);
  end

  // Strobes evaluated against the values that will be visible after this edge.
  always_comb begin
    period_ext  = {1'b0, period_next} + (CNT_WIDTH + 1)'(1);
    // Sawtooth window start, saturated at zero for short periods.
    saw_thresh  = (period_ext > CaptureWin) ? period_ext - CaptureWin : '0;
    new_cycle_d = (state_d == ST_RUN) && (count_d == '0);
    peak_d      = (state_d == ST_RUN) && (count_d == period_next);
    capture_d   = 1'b0;
    if (state_d == ST_RUN) begin
      if (mode_next == MODE_SAWTOOTH) begin
        capture_d = ({1'b0, count_d} >= saw_thresh);
      end else begin
        capture_d = dir_d && (count_d != '0) && ({1'b0, count_d} <= CaptureWin);
      end
    end
  end

  // Registered carrier outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      carrier_count <= '0;
      count_dir     <= 1'b0;
      new_cycle     <= 1'b0;
      peak          <= 1'b0;
      data_capture  <= 1'b0;
    end else begin
      state_q       <= state_d;
      carrier_count <= count_d;
      count_dir     <= dir_d;
      new_cycle     <= new_cycle_d;
      peak          <= peak_d;
      data_capture  <= capture_d;
    end
  end

endmodule

// File: doc/pwm_carrier_gen.md
Name: pwm_carrier_gen

Overview:
- Parametrised PWM carrier generator, the successor to the fixed 5 kHz triangle counter.
- Produces a triangle (up/down) or sawtooth (up-only) carrier with run-time programmable peak. Peak and mode are shadow-loaded only at the valley.
- Provides valley, peak and ADC data-capture strobes, plus a sync input to align several converters.
- Feeds the PWM comparators and ADC/current-sampling logic of the vector-control datapath.

Parameters:
- CNT_WIDTH, 16: width of the counter, period_in, carrier_count and active_period.
- RESET_PERIOD, 4000: active peak after reset. Triangle period is 2*4000 = 8000 clk, i.e. 5 kHz at 40 MHz.
- CAPTURE_WIN, 100: length in clk of the data_capture window that ends at the valley.
- MIN_PERIOD, 2: lower clamp for the loaded peak.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run when high; synchronous return to idle when low.
- sync_in  in  1  single-cycle pulse; restarts the carrier at the valley.
- mode_in  in  1  0 = triangle, 1 = sawtooth; shadow-loaded.
- period_in  in  CNT_WIDTH  requested peak value P; shadow-loaded.
- carrier_count  out  CNT_WIDTH  carrier value, registered.
- count_dir  out  1  1 = counting down (triangle only).
- new_cycle  out  1  high exactly in cycles where carrier_count == 0 during RUN.
- peak  out  1  high exactly in cycles where carrier_count == active_period.
- data_capture  out  1  capture window strobe.
- active_period  out  CNT_WIDTH  peak value currently in use.

Behaviour:
- Reset (async):
  - State IDLE; carrier_count = 0; count_dir = 0.
  - new_cycle, peak and data_capture = 0.
  - active_period = RESET_PERIOD; active mode = triangle.
- All outputs are registered and update together on the clock edge.
- Priority per edge: reset > enable low > sync_in > normal counting.
- IDLE:
  - carrier_count = 0 and all strobes 0.
  - active_period and active mode track the clamped period_in / mode_in every cycle.
  - Edge with enable = 1: go to RUN. carrier_count stays 0, new_cycle = 1, count_dir = 0.
- RUN, enable = 0 on an edge: go to IDLE with the IDLE output values on that same edge.
- RUN, triangle mode:
  - Count goes 0, 1 … P, P-1 … 1, 0, 1 … (period 2P clk).
  - count_dir becomes 1 on the edge that loads P; it becomes 0 on the edge that loads 0.
- RUN, sawtooth mode:
  - Count goes 0 … P, 0 … (period P+1 clk); count_dir is always 0.
- Shadow load:
  - Happens on any edge whose next carrier_count is 0: the valley, a sync restart or the IDLE→RUN transition.
  - active_period <= max(period_in, MIN_PERIOD); active mode <= mode_in.
  - Changes to period_in or mode_in mid-cycle have no effect until the next valley.
- sync_in in RUN:
  - On that edge: carrier_count = 0, count_dir = 0, new_cycle = 1, shadow load.
  - sync_in arriving exactly at the natural valley has the same result; no double pulse.
- data_capture window:
  - Triangle: high when count_dir = 1 and 1 <= carrier_count <= CAPTURE_WIN.
  - Sawtooth: high when carrier_count >= active_period - CAPTURE_WIN + 1, with saturation at 0.
  - Window length is min(CAPTURE_WIN, slope length).
- Arithmetic: unsigned CNT_WIDTH; the counter never exceeds active_period, so there is no wrap-around.
- Design rule: active_period must be at most 2^CNT_WIDTH - 1.

Decomposition:
- Shared package pwm_pkg holds:
  - carrier mode constants MODE_TRIANGLE = 0 and MODE_SAWTOOTH = 1;
  - state encoding ST_IDLE / ST_RUN;
  - default CNT_WIDTH and RESET_PERIOD.
- Natural sub-module: pwm_shadow_reg. It holds the clamp and the valley-gated load of active_period and mode, and is reused later for the compare-value shadow registers.

Test Plan:
- Triangle: reset, period_in = 4, CAPTURE_WIN = 2, enable = 1.
  - carrier_count = 0,1,2,3,4,3,2,1,0,1…
  - new_cycle at each 0; peak at each 4.
  - data_capture high only at the downward 2 and 1.
- Sawtooth: mode_in = 1, period_in = 4, CAPTURE_WIN = 2.
  - carrier_count = 0,1,2,3,4,0…
  - data_capture high at 3 and 4; count_dir always 0.
- Shadow load: triangle with P = 4; change period_in to 6 at count 2 (rising).
  - Current cycle still peaks at 4.
  - After the next 0, the counter peaks at 6 and active_period = 6.
- Clamp: period_in = 0 at enable, mode triangle → active_period = 2; sequence 0,1,2,1,0.
- Sync: P = 8; pulse sync_in at count 5 (falling).
  - Next carrier_count = 0 with new_cycle = 1, then 1,2…
  - sync_in at a natural valley → a single new_cycle pulse.
- Reset and disable mid-run: P = 4 running at count 3.
  - Asserting reset sets all outputs to reset values immediately (async).
  - Dropping enable at count 3 gives carrier_count = 0 and strobes 0 on the next edge.
  - Re-enabling gives new_cycle = 1 on the first edge.
